viol_reset_seq: RTL

- Consumer end of the hardware-monitor violation path: the monitors (atomicity, key access, DMA guards) raise level violation requests, and this block turns them into a clean, stretched reset for the MSP430 core.
- Latches which monitor(s) fired and counts violation events.
- Completes the handshake only when the core fetches the reset vector; the monitors release their requests on that same event.
- Sits between the monitor bank and the core reset input.

---
 rtl/viol_reset_seq_if.sv | 37 +++
 rtl/viol_reset_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/viol_reset_seq_if.sv
// -----------------------------------------------------------------------------
// viol_reset_seq_if
//   Signal bundle between the violation monitor bank / MSP430 core side and the
//   violation reset sequencer.
//
//   viol_req   [NUM_SRC] level violation requests from the monitors
//   pc         [16]      current core program counter
//   clr_cause  [1]       pulse that clears the sticky cause record
//   core_rst   [1]       stretched reset to the core, active-high
//   viol_cause [NUM_SRC] sticky record of the sources of the last episode
//   viol_count [8]       saturating count of violation episodes
//   busy       [1]       sequencer is not idle
//
//   master : monitor bank / core / software side
//   slave  : viol_reset_seq
// -----------------------------------------------------------------------------
interface viol_reset_seq_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0] viol_req;
  logic [15:0]        pc;
  logic               clr_cause;
  logic               core_rst;
  logic [NUM_SRC-1:0] viol_cause;
  logic [7:0]         viol_count;
  logic               busy;

  modport master (
    output viol_req, pc, clr_cause,
    input  core_rst, viol_cause, viol_count, busy
  );

  modport slave (
    input  viol_req, pc, clr_cause,
    output core_rst, viol_cause, viol_count, busy
  );
endinterface

// File: rtl/viol_reset_seq.sv
// -----------------------------------------------------------------------------
// viol_reset_seq
//   Turns level violation requests from the hardware monitors into a clean,
//   stretched reset for the MSP430 core. Latches which monitor(s) fired,
//   counts violation episodes, and completes the handshake only once the core
//   fetches the reset vector (the monitors drop their requests on that fetch).
//
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset; starts a full reset episode that
//            is not counted
//   bus  viol_reset_seq_if.slave
//          viol_req   in  level violation requests
//          pc         in  core program counter, looked at only in WAIT_VEC
//          clr_cause  in  clears viol_cause, honoured only in IDLE
//          core_rst   out registered reset to the core
//          viol_cause out sticky cause of the last episode
//          viol_count out episode count, saturating at 255
//          busy       out high in every state except IDLE
//
// Build option:
//   VIOL_LOCK_EN  when defined, the episode that brings viol_count to
//                 LOCK_THRESHOLD or above parks the block in LOCKED, holding
//                 the core in reset until rst.
//
// State     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no violation in progress, core running
// HOLD      | core_rst asserted, hold counter running
// WAIT_VEC  | core released, waiting for the reset-vector fetch (with timeout)
// GUARD     | 2 cycles ignoring requests while the monitors deassert
// LOCKED    | permanent reset until rst (VIOL_LOCK_EN builds only)
// -----------------------------------------------------------------------------
module viol_reset_seq #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter logic [15:0] RESET_HANDLER  = 16'hfffe,
  parameter int unsigned ACK_TIMEOUT    = 64,
  parameter int unsigned LOCK_THRESHOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  viol_reset_seq_if.slave  bus
);

  // Elaboration-time parameter sanity checks.
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 256) begin : g_bad_hold
    $error("viol_reset_seq: HOLD_CYCLES must be within 2..256");
  end
  if (ACK_TIMEOUT < 2 || ACK_TIMEOUT > 256) begin : g_bad_ack
    $error("viol_reset_seq: ACK_TIMEOUT must be within 2..256");
  end
  if (LOCK_THRESHOLD < 1 || LOCK_THRESHOLD > 255) begin : g_bad_lock
    $error("viol_reset_seq: LOCK_THRESHOLD must be within 1..255");
  end

  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] ACK_LOAD   = 8'(ACK_TIMEOUT - 1);
  // GUARD reuses the hold counter: a load of 1 gives exactly two cycles.
  localparam logic [7:0] GUARD_LOAD = 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_VEC = 3'd2,
    ST_GUARD    = 3'd3
`ifdef VIOL_LOCK_EN
    ,
    ST_LOCKED   = 3'd4
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [7:0]         ack_cnt_q, ack_cnt_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic [7:0]         count_q, count_d;
  logic               core_rst_q, core_rst_d;
  logic               busy_q, busy_d;

  logic               any_req;
  logic [7:0]         count_inc;
  logic               vec_seen;

  assign any_req   = |bus.viol_req;
  assign count_inc = (count_q == 8'hff) ? 8'hff : count_q + 8'd1;
  assign vec_seen  = (bus.pc == RESET_HANDLER);

`ifdef VIOL_LOCK_EN
  logic lock_hit;
  assign lock_hit = ({24'd0, count_inc} >= LOCK_THRESHOLD);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= HOLD_LOAD;
      ack_cnt_q  <= 8'd0;
      cause_q    <= '0;
      count_q    <= 8'd0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    cause_d    = cause_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // A request in the same cycle as clr_cause wins over the clear.
          cause_d    = bus.clr_cause ? bus.viol_req : (cause_q | bus.viol_req);
          count_d    = count_inc;
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
`ifdef VIOL_LOCK_EN
          if (lock_hit) begin
            state_d = ST_LOCKED;
          end
`endif
        end else if (bus.clr_cause) begin
          cause_d = '0;
        end
      end

      ST_HOLD: begin
        // Late-arriving sources join the current episode without a new count.
        cause_d = cause_q | bus.viol_req;
        if (hold_cnt_q == 8'd0) begin
          ack_cnt_d = ACK_LOAD;
          state_d   = ST_WAIT_VEC;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end

      ST_WAIT_VEC: begin
        // Requests are still up here by design; only the vector fetch matters.
        if (vec_seen) begin
          hold_cnt_d = GUARD_LOAD;
          state_d    = ST_GUARD;
        end else if (ack_cnt_q == 8'd0) begin
          // Core never fetched the vector: retry the hold, same episode.
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end else begin
          ack_cnt_d = ack_cnt_q - 8'd1;
        end
      end

      ST_GUARD: begin
        if (hold_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end

`ifdef VIOL_LOCK_EN
      ST_LOCKED: begin
        cause_d = cause_q | bus.viol_req;
      end
`endif

      default: begin
        // Unreachable encodings fall back into a full reset episode.
        hold_cnt_d = HOLD_LOAD;
        state_d    = ST_HOLD;
      end
    endcase

`ifdef VIOL_LOCK_EN
    core_rst_d = (state_d == ST_HOLD) || (state_d == ST_LOCKED);
`else
    core_rst_d = (state_d == ST_HOLD);
`endif
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.core_rst   = core_rst_q;
  assign bus.viol_cause = cause_q;
  assign bus.viol_count = count_q;
  assign bus.busy       = busy_q;

endmodule
